bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the sequence-detector datapath. Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock on `dout`. `dout` is the single-bit `din` stream consumed by the sequence detector. Back-to-back words stream with no idle gap, so the detector sees a continuous bit sequence across word boundaries.

## Interface
- `WIDTH`, 8: word length in bits, ≥1.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
- `IDLE_BIT`, 0: value driven on `dout` when no word is being sent.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset; synchronous, active-low (`reset`==0 resets on the next rising `clk`).
- `data_in`  in  WIDTH  word to serialize; sampled on an accept edge.
- `load_valid`  in  1  `data_in` is valid.
- `load_ready`  out  1  block can accept a word this cycle.
- `dout`  out  1  serial bit, registered.
- `dout_valid`  out  1  `dout` carries a data bit.
- `frame_start`  out  1  high while `dout` carries the first bit of a word.
- `frame_end`  out  1  high while `dout` carries the last bit of a word.

## Operation
- State registers: `state` ∈ {IDLE, SHIFT}, `shreg`[WIDTH-1:0], `cnt` (index of the bit currently on `dout`, 0..WIDTH-1, width clog2(WIDTH) with minimum 1).
- Accept = `load_valid && load_ready` at a rising edge with `reset`==1.
- `load_ready` = (`state`==IDLE) || (`state`==SHIFT && `cnt`==WIDTH-1). It is a function of registers only; no combinational path from any input.
- **IDLE:**
  - On accept: load `shreg` ← `data_in`, `cnt` ← 0, go to SHIFT.
  - Otherwise hold, with `dout`=IDLE_BIT and all flags 0.
- **SHIFT:**
  - `dout` = `shreg`[WIDTH-1] if MSB_FIRST, else `shreg`[0].
  - `dout_valid`=1; `frame_start` = (`cnt`==0); `frame_end` = (`cnt`==WIDTH-1).
  - If `cnt` < WIDTH-1: shift `shreg` one position toward the output end and increment `cnt`. `load_valid` is ignored.
  - If `cnt`==WIDTH-1 and accept: reload `shreg`, set `cnt` ← 0, stay in SHIFT. This is the gapless path.
  - If `cnt`==WIDTH-1 and no accept: go to IDLE.
- `dout`, `dout_valid`, `frame_start`, `frame_end` are registered outputs.
- WIDTH=1: every bit has `frame_start`=`frame_end`=1. `load_ready` stays 1 throughout SHIFT.
- `data_in` changes while not accepting have no effect.

## Timing
- Reset: at the first rising edge with `reset`==0:
  - `state`=IDLE, `shreg`=0, `cnt`=0.
  - `dout`=IDLE_BIT, `dout_valid`=0, `frame_start`=0, `frame_end`=0, `load_ready`=1 (the IDLE value).
- While `reset`==0, `load_valid` is ignored.
- Latency: a word accepted at edge k puts its first bit on `dout` from edge k to edge k+1. The last bit occupies edge k+WIDTH-1 to edge k+WIDTH.
- Throughput: one bit per clock; one word per WIDTH clocks under continuous `load_valid`.
- Return to idle: with no new word, `dout` returns to IDLE_BIT and `dout_valid` to 0 at edge k+WIDTH.
- Reset mid-word: the word is aborted. Remaining bits are never emitted, and outputs take their reset values at that edge. A word offered by `load_valid` on the same edge as the reset is discarded.
- `load_valid` held high in SHIFT with `cnt` < WIDTH-1 has no effect and does not stall; the word is taken only when `load_ready` rises.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `load_valid`=1 and `data_in`=8'hFF.
  - Expect `dout`=0, `dout_valid`=0, `load_ready`=1, and no word accepted.
- **Single word, MSB_FIRST=1:** `data_in`=8'hE0, pulse `load_valid` for 1 cycle.
  - Expect `dout` = 1,1,1,0,0,0,0,0 over the next 8 cycles.
  - `frame_start` high on cycle 1 only; `frame_end` high on cycle 8 only.
  - Then `dout`=0 and `dout_valid`=0.
- **Back-to-back:** keep `load_valid`=1 with 8'hA5 then 8'h3C.
  - Expect 16 contiguous valid bits: 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - `load_ready` high on cycles 8 and 16; no idle gap.
- **LSB-first:** MSB_FIRST=0, `data_in`=8'h07.
  - Expect `dout` = 1,1,1,0,0,0,0,0.
  - Downstream sees three consecutive 1s starting at `frame_start`.
- **Reset mid-word:** drive `reset`=0 during cycle 4 of 8'hFF.
  - Expect `dout`=0 and `dout_valid`=0 from that edge on.
  - Bits 5-8 are never emitted; a fresh word is accepted in the first cycle after `reset`=1.
- **WIDTH=1:** stream bits 1,1,0,1.
  - Expect `dout` = 1,1,0,1 with `frame_start`=`frame_end`=`dout_valid`=1 on every cycle and `load_ready` constantly 1.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word on a valid/ready handshake and
// emits it one bit per clock on dout, streaming consecutive words without an idle gap.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic dout_d, dout_valid_d, frame_start_d, frame_end_d;
    logic last, accept;

    // Ready depends on registers only, so there is no combinational path from load_valid.
    assign last       = (cnt_q == LAST);
    assign load_ready = (state_q == StIdle) || last;
    assign accept     = load_valid && load_ready;

    // State register, including the registered serial outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            dout        <= IDLE_BIT;
            dout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            dout        <= dout_d;
            dout_valid  <= dout_valid_d;
            frame_start <= frame_start_d;
            frame_end   <= frame_end_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!last) begin
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + 1'b1;
                end else if (accept) begin
                    // Gapless reload: next word's first bit follows the last bit directly.
                    shreg_d = data_in;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output values for the next cycle, decoded from next state so they can be registered.
    always_comb begin
        dout_d        = IDLE_BIT;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        if (state_d == StShift) begin
            dout_d        = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
            dout_valid_d  = 1'b1;
            frame_start_d = (cnt_d == '0);
            frame_end_d   = (cnt_d == LAST);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first, LSB-first and WIDTH=1 instances on a shared
// clock and reset, with hand-computed bit sequences.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MSB-first, WIDTH=8
    logic [7:0] m_data;
    logic m_valid, m_ready, m_dout, m_dvalid, m_fs, m_fe;
    // LSB-first, WIDTH=8
    logic [7:0] l_data;
    logic l_valid, l_ready, l_dout, l_dvalid, l_fs, l_fe;
    // WIDTH=1
    logic [0:0] w_data;
    logic w_valid, w_ready, w_dout, w_dvalid, w_fs, w_fe;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .data_in(m_data), .load_valid(m_valid),
        .load_ready(m_ready), .dout(m_dout), .dout_valid(m_dvalid),
        .frame_start(m_fs), .frame_end(m_fe)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_in(l_data), .load_valid(l_valid),
        .load_ready(l_ready), .dout(l_dout), .dout_valid(l_dvalid),
        .frame_start(l_fs), .frame_end(l_fe)
    );

    bit_serializer #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
        .clk(clk), .reset(reset), .data_in(w_data), .load_valid(w_valid),
        .load_ready(w_ready), .dout(w_dout), .dout_valid(w_dvalid),
        .frame_start(w_fs), .frame_end(w_fe)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable until the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  w8;
    logic [15:0] w16;
    logic [3:0]  wbits;

    initial begin
        reset   = 1'b0;
        m_valid = 1'b1; m_data = 8'hFF;
        l_valid = 1'b0; l_data = 8'h00;
        w_valid = 1'b0; w_data = 1'b0;

        // Reset held low with a word offered: must be discarded.
        tick(); tick();
        check("rst_dout", m_dout, 1'b0);
        check("rst_dvalid", m_dvalid, 1'b0);
        check("rst_ready", m_ready, 1'b1);
        check("rst_fs", m_fs, 1'b0);
        check("rst_fe", m_fe, 1'b0);
        reset = 1'b1; m_valid = 1'b0;
        tick();
        check("rst_no_accept", m_dvalid, 1'b0);

        // Single word, MSB first.
        w8 = 8'hE0;
        m_data = w8; m_valid = 1'b1;
        tick();
        m_valid = 1'b0; m_data = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            check("single_dout", m_dout, w8[7-i]);
            check("single_dvalid", m_dvalid, 1'b1);
            check("single_fs", m_fs, i == 0);
            check("single_fe", m_fe, i == 7);
            tick();
        end
        check("single_idle_dout", m_dout, 1'b0);
        check("single_idle_dvalid", m_dvalid, 1'b0);
        check("single_idle_ready", m_ready, 1'b1);

        // Back-to-back words with load_valid held high.
        w16 = 16'hA53C;
        m_data = 8'hA5; m_valid = 1'b1;
        tick();
        m_data = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            check("b2b_dout", m_dout, w16[15-i]);
            check("b2b_dvalid", m_dvalid, 1'b1);
            check("b2b_ready", m_ready, (i == 7) || (i == 15));
            check("b2b_fs", m_fs, (i == 0) || (i == 8));
            check("b2b_fe", m_fe, (i == 7) || (i == 15));
            if (i == 15) m_valid = 1'b0;
            tick();
        end
        check("b2b_idle_dvalid", m_dvalid, 1'b0);

        // LSB first.
        w8 = 8'h07;
        l_data = w8; l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb_dout", l_dout, w8[i]);
            check("lsb_dvalid", l_dvalid, 1'b1);
            check("lsb_fs", l_fs, i == 0);
            check("lsb_fe", l_fe, i == 7);
            tick();
        end
        check("lsb_idle_dvalid", l_dvalid, 1'b0);

        // Reset during the fourth bit of 8'hFF aborts the word.
        m_data = 8'hFF; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_pre_dout", m_dout, 1'b1);
            if (i < 3) tick();
        end
        reset = 1'b0;
        tick();
        check("abort_dout", m_dout, 1'b0);
        check("abort_dvalid", m_dvalid, 1'b0);
        check("abort_ready", m_ready, 1'b1);
        reset = 1'b1;
        w8 = 8'h81;
        m_data = w8; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("fresh_dout", m_dout, w8[7-i]);
            check("fresh_dvalid", m_dvalid, 1'b1);
            check("fresh_fs", m_fs, i == 0);
            tick();
        end
        check("fresh_idle_dvalid", m_dvalid, 1'b0);

        // WIDTH=1 streaming 1,1,0,1.
        wbits = 4'b1011;  // bit i is the i-th streamed bit
        w_data = wbits[0]; w_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("w1_dout", w_dout, wbits[i]);
            check("w1_dvalid", w_dvalid, 1'b1);
            check("w1_fs", w_fs, 1'b1);
            check("w1_fe", w_fe, 1'b1);
            check("w1_ready", w_ready, 1'b1);
            if (i < 3) w_data = wbits[i+1];
            else       w_valid = 1'b0;
            tick();
        end
        check("w1_idle_dvalid", w_dvalid, 1'b0);
        check("w1_idle_dout", w_dout, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
